// File: rtl/y86_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : y86_alu_pipe
// Description : Registered Y86 OPq execute-stage ALU (add/sub/and/xor) with a
//               valid/ready output stage and ZF/SF/OF condition-code register.
//               Optional macro ALU_SHIFT_EN adds fn 4 (shl) and fn 5 (sar).
// Revision    : 1.0 - initial release
// ============================================================================
module y86_alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_fn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    localparam int MSB = WIDTH - 1;
`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
`endif

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             alu_of;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        alu_of  = 1'b0;
        case (in_fn)
            4'd0: begin
                alu_res = in_b + in_a;
                alu_of  = (in_a[MSB] == in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
            end
            4'd1: begin
                // Y86 subq computes valB - valA
                alu_res = in_b - in_a;
                alu_of  = (in_a[MSB] != in_b[MSB]) && (alu_res[MSB] != in_b[MSB]);
            end
            4'd2: alu_res = in_b & in_a;
            4'd3: alu_res = in_b ^ in_a;
`ifdef ALU_SHIFT_EN
            4'd4: alu_res = in_b << in_a[SHW-1:0];
            4'd5: alu_res = $signed(in_b) >>> in_a[SHW-1:0];
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            cc_zf      <= 1'b1;
            cc_sf      <= 1'b0;
            cc_of      <= 1'b0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_result <= alu_res;
                out_err    <= alu_err;
                if (in_set_cc && !alu_err) begin
                    cc_zf <= (alu_res == '0);
                    cc_sf <= alu_res[MSB];
                    cc_of <= alu_of;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_alu_pipe
// Description : Self-checking bench for y86_alu_pipe (WIDTH=64), directed plus
//               randomized steps against an exact-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_fn;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_err;
    logic        cc_zf;
    logic        cc_sf;
    logic        cc_of;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected architectural state
    bit          m_valid;
    logic [63:0] m_res;
    bit          m_err;
    bit          m_zf;
    bit          m_sf;
    bit          m_of;

    y86_alu_pipe #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fn     (in_fn),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_set_cc (in_set_cc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_err   (out_err),
        .cc_zf     (cc_zf),
        .cc_sf     (cc_sf),
        .cc_of     (cc_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {err, of, result}; overflow judged by exact signed arithmetic
    function automatic logic [65:0] ref_alu(input logic [3:0] fn, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [65:0] wide;
        logic [63:0]        r;
        logic               err;
        logic               of;
        r = '0; err = 1'b0; of = 1'b0;
        wide = '0;
        case (fn)
            4'd0: begin
                wide = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
                r    = wide[63:0];
                of   = (wide != $signed({{2{r[63]}}, r}));
            end
            4'd1: begin
                wide = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
                r    = wide[63:0];
                of   = (wide != $signed({{2{r[63]}}, r}));
            end
            4'd2: r = b & a;
            4'd3: r = b ^ a;
`ifdef ALU_SHIFT_EN
            4'd4: r = b << a[5:0];
            4'd5: r = $signed(b) >>> a[5:0];
`endif
            default: err = 1'b1;
        endcase
        return {err, of, r};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk({tag, ".out_result"}, out_result, m_res);
            chk({tag, ".out_err"}, {63'd0, out_err}, {63'd0, m_err});
        end
        chk({tag, ".cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
    endtask

    // Called at posedge+1; drives, checks in_ready at negedge, clocks, checks outputs
    task automatic step(input string tag, input bit v, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b,
                        input bit scc, input bit ordy);
        logic [65:0] ref_out;
        bit          acc;
        in_valid = v; in_fn = fn; in_a = a; in_b = b; in_set_cc = scc; out_ready = ordy;
        #4;
        chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, (!m_valid || ordy)});
        @(posedge clk);
        acc = v && (!m_valid || ordy);
        if (acc) begin
            ref_out = ref_alu(fn, a, b);
            m_valid = 1'b1;
            m_res   = ref_out[63:0];
            m_err   = ref_out[65];
            if (scc && !ref_out[65]) begin
                m_zf = (ref_out[63:0] == 64'd0);
                m_sf = ref_out[63];
                m_of = ref_out[64];
            end
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_res = '0; m_err = 1'b0;
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom % 5)
            0: v = 64'h7FFF_FFFF_FFFF_FFFF;
            1: v = 64'h8000_0000_0000_0000;
            2: v = 64'({$urandom % 4});
            3: v = 64'hFFFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_fn = '0; in_a = '0; in_b = '0;
        in_set_cc = 1'b0; out_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset.out_result", out_result, 64'd0);
        chk("reset.out_err", {63'd0, out_err}, 64'd0);
        chk("reset.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        chk("reset.in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;

        step("idle", 0, 4'd0, 64'd0, 64'd0, 0, 1);

        step("add_ovf", 1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 1);
        chk("add_ovf.const", out_result, 64'h8000_0000_0000_0000);
        chk("add_ovf.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);

        step("sub_zero", 1, 4'd1, 64'h1234, 64'h1234, 1, 1);
        chk("sub_zero.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        step("add_neg", 1, 4'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd1, 1, 1);
        step("sub_nocc", 1, 4'd1, 64'h1234, 64'h1234, 0, 1);
        chk("sub_nocc.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);

        step("xor0", 1, 4'd3, 64'hFF00, 64'h0FF0, 1, 1);
        chk("xor0.const", out_result, 64'hF0F0);
        step("xor1", 1, 4'd3, 64'hFF00, 64'hFFFF, 1, 1);
        step("xor2", 1, 4'd3, 64'h00FF, 64'h0FF0, 1, 1);
        step("xor3", 1, 4'd3, 64'hFF00, 64'hFF00, 1, 1);
        step("drain", 0, 4'd0, 64'd0, 64'd0, 0, 1);

        step("bp_load", 1, 4'd2, 64'hF0F0, 64'hFFFF, 1, 1);
        for (int i = 0; i < 3; i++)
            step("bp_stall", 1, 4'd0, 64'd5, 64'd6, 1, 0);
        chk("bp_stall.hold", out_result, 64'hF0F0);
        step("bp_release", 1, 4'd0, 64'd5, 64'd6, 1, 1);
        chk("bp_release.const", out_result, 64'd11);

        step("illegal", 1, 4'd7, 64'd3, 64'd9, 1, 1);
        chk("illegal.err", {63'd0, out_err}, 64'd1);
`ifdef ALU_SHIFT_EN
        step("shl", 1, 4'd4, 64'd4, 64'd1, 1, 1);
        chk("shl.const", out_result, 64'h10);
`else
        step("fn4_illegal", 1, 4'd4, 64'd4, 64'd1, 1, 1);
        chk("fn4_illegal.err", {63'd0, out_err}, 64'd1);
`endif

        // Asynchronous reset while a result is held under backpressure
        step("pre_rst", 1, 4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst.cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_outputs("post_rst");

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom % 4) != 0, 4'($urandom % 8), pick_operand(),
                 pick_operand(), ($urandom % 3) != 0, ($urandom % 3) != 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
